// File: rtl/hex_scan_display.sv
// hex_scan_display
//   Time-multiplexed driver for an N-digit common-anode 7-segment display.
//   One shared segment bus is scanned across the digits. Display data is
//   double-buffered and swapped only at frame boundaries. Supports per-digit
//   blink and leading-zero blanking.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   codes       4-bit display codes, codes[3:0] = digit 0 (rightmost)
//   blink_mask  1 = digit blinks
//   load        capture codes/blink_mask into the pending buffer
//   blank_lz    enable leading-zero blanking (used live, not buffered)
//   ready       1 = no pending update
//   HEX         segments a..g (HEX[0] = a), active-low
//   DIG_EN      digit enables, active-low, one-hot-low
//   frame       one-cycle pulse after each frame boundary
module hex_scan_display #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic                    ready,
    output logic [0:6]              HEX,
    output logic [NUM_DIGITS-1:0]   DIG_EN,
    output logic                    frame
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned PreW = $clog2(SCAN_DIV);
    localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);
    localparam logic [FrmW-1:0] FrmMax = FrmW'(BLINK_FRAMES - 1);

    localparam logic [0:6] SegBlank = 7'b1111111;

    // Code map, bit 0 of the result is segment a, 0 = lit.
    function automatic logic [0:6] seg_decode(input logic [3:0] c);
        logic [0:6] s;
        s = SegBlank;
        unique case (c)
            4'd0:  s = 7'b0000001;
            4'd1:  s = 7'b1001111;
            4'd2:  s = 7'b0010010;
            4'd3:  s = 7'b0000110;
            4'd4:  s = 7'b1001100;
            4'd5:  s = 7'b0100100;
            4'd6:  s = 7'b0100000;
            4'd7:  s = 7'b0001111;
            4'd8:  s = 7'b0000000;
            4'd9:  s = 7'b0000100;
            4'd10: s = 7'b0001000;  // A
            4'd11: s = 7'b0011000;  // P
            4'd12: s = 7'b1001110;  // -/
            4'd13: s = 7'b1111000;  // /-
            4'd14: s = 7'b1111110;  // -
            4'd15: s = 7'b1111111;  // blank
        endcase
        return s;
    endfunction

    logic [PreW-1:0]         pre_q, pre_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [FrmW-1:0]         frm_q, frm_d;
    logic                    phase_q, phase_d;  // 1 = blink ON (visible)
    logic                    pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0] pend_codes_q, pend_codes_d;
    logic [NUM_DIGITS-1:0]   pend_mask_q, pend_mask_d;
    logic [4*NUM_DIGITS-1:0] act_codes_q, act_codes_d;
    logic [NUM_DIGITS-1:0]   act_mask_q, act_mask_d;
    logic [0:6]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                    frame_q, frame_d;

    logic                    tick;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    zero_run;
    logic [3:0]              cur_code;
    logic                    cur_blink;
    logic                    cur_lz;
    logic                    seg_off;

    // Scan timing, frame/blink counters and the update handshake.
    always_comb begin
        tick     = (pre_q == PreMax);
        boundary = tick && (idx_q == IdxMax);

        pre_d        = tick ? '0 : pre_q + 1'b1;
        idx_d        = idx_q;
        frm_d        = frm_q;
        phase_d      = phase_q;
        pend_valid_d = pend_valid_q;
        pend_codes_d = pend_codes_q;
        pend_mask_d  = pend_mask_q;
        act_codes_d  = act_codes_q;
        act_mask_d   = act_mask_q;
        frame_d      = boundary;

        if (tick) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end

        if (boundary) begin
            if (frm_q == FrmMax) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
            if (pend_valid_q) begin
                act_codes_d  = pend_codes_q;
                act_mask_d   = pend_mask_q;
                pend_valid_d = 1'b0;
            end
        end

        // A load on the boundary cycle lands in pending after the old
        // pending value has already moved to active.
        if (load) begin
            pend_codes_d = codes;
            pend_mask_d  = blink_mask;
            pend_valid_d = 1'b1;
        end
    end

    // Segment/enable generation for the digit currently selected.
    always_comb begin
        // lz[i] = all active codes from the top digit down to i are zero.
        lz       = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_codes_q[4*i +: 4] == 4'd0);
            lz[i]    = zero_run;
        end

        cur_code  = 4'hF;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IdxW'(i) == idx_q) begin
                cur_code  = act_codes_q[4*i +: 4];
                cur_blink = act_mask_q[i];
                cur_lz    = lz[i];
            end
        end

        seg_off  = (cur_blink && !phase_q) || (blank_lz && (idx_q != '0) && cur_lz);
        hex_d    = seg_off ? SegBlank : seg_decode(cur_code);
        dig_en_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q        <= '0;
            idx_q        <= '0;
            frm_q        <= '0;
            phase_q      <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_codes_q <= '1;
            pend_mask_q  <= '0;
            act_codes_q  <= '1;
            act_mask_q   <= '0;
            hex_q        <= SegBlank;
            dig_en_q     <= '1;
            frame_q      <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            frm_q        <= frm_d;
            phase_q      <= phase_d;
            pend_valid_q <= pend_valid_d;
            pend_codes_q <= pend_codes_d;
            pend_mask_q  <= pend_mask_d;
            act_codes_q  <= act_codes_d;
            act_mask_q   <= act_mask_d;
            hex_q        <= hex_d;
            dig_en_q     <= dig_en_d;
            frame_q      <= frame_d;
        end
    end

    assign ready  = ~pend_valid_q;
    assign HEX    = hex_q;
    assign DIG_EN = dig_en_q;
    assign frame  = frame_q;

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display using the team's 4-bit display code set (0-9, A, P, -/, /-, -, blank). Replaces per-digit static decoders: one shared segment bus is scanned across digits. Adds frame-synchronous double-buffered update, per-digit blink and leading-zero blanking. Sits between control FSMs and board pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits (>=2)
SCAN_DIV, 50000, clk cycles each digit is enabled (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
codes  in  4*NUM_DIGITS  display codes; codes[3:0] = digit 0 (rightmost)
blink_mask  in  NUM_DIGITS  1 = digit blinks
load  in  1  capture codes/blink_mask into pending buffer
blank_lz  in  1  enable leading-zero blanking
ready  out  1  1 = no pending update
HEX  out  [0:6]  segments a..g, active-low
DIG_EN  out  NUM_DIGITS  digit enables, active-low, one-hot-low
frame  out  1  one-cycle pulse at frame boundary

Behaviour:
- Reset is asynchronous, active-high (already decided). Reset values: HEX=7'b111_1111, DIG_EN=all 1, ready=1, frame=0; prescaler=0, digit index=0, blink phase=ON, frame count=0, pending_valid=0, active codes=all 4'b1111 (blank), active blink_mask=0.
- Code map (HEX[0..6]=a..g, 0=lit): 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0000100 A(10):0001000 P(11):0011000 -/(12):1001110 /-(13):1111000 -(14):1111110 15:1111111 blank.
- Prescaler counts 0..SCAN_DIV-1; tick when ==SCAN_DIV-1, then wraps to 0.
- On tick, index advances; NUM_DIGITS-1 wraps to 0. Tick while index==NUM_DIGITS-1 = frame boundary: frame=1 for the following cycle.
- HEX and DIG_EN are registered: one cycle after index changes, DIG_EN[index]=0 (others 1) and HEX = decoded segment value for index. Exactly one DIG_EN bit low at all times after the first post-reset cycle.
- Segment value for digit i = 1111111 if: (a) blink_mask_active[i]=1 and blink phase=OFF, or (b) blank_lz=1, i>0, and all active codes from digit NUM_DIGITS-1 down to i equal 0. Otherwise the code map value. Digit 0 is never LZ-blanked.
- Blink: frame counter counts boundaries 0..BLINK_FRAMES-1; on reaching BLINK_FRAMES-1 at a boundary it wraps and phase toggles.
- Update handshake: load=1 captures codes and blink_mask into pending, pending_valid=1, ready=0 next cycle. load while pending: pending overwritten, last value wins.
- At a boundary with pending_valid=1: pending -> active, pending_valid=0, ready=1 next cycle. New values are first displayed on digit 0 of the new frame. Active registers never change mid-frame.
- load in the same cycle as a boundary: existing pending (if any) transfers to active; new load value enters pending, ready stays 0, applied at the next boundary.
- blank_lz is sampled live (not buffered).
- Reset asserted mid-frame: all state returns to reset values immediately; pending data is discarded.

Test Plan:
- Reset, then 2 cycles; SCAN_DIV=4, NUM_DIGITS=4 -> HEX=1111111 (blank) on all digits; DIG_EN steps 1110,1101,1011,0111 every 4 cycles; frame pulses every 16 cycles.
- load codes=16'h12A5 mid-frame -> ready=0 until boundary; old (blank) values shown for the rest of the frame; next frame digit0=0100100, digit1=0001000, digit2=0010010, digit3=1001111; ready=1.
- codes=16'h0070, blank_lz=1 -> digit3 and digit2 blank, digit1=0001111, digit0=0000001; codes=16'h0000 -> only digit0 lit as 0000001.
- blink_mask=4'b0010, BLINK_FRAMES=2 -> digit1 lit for 2 frames, blank for 2 frames, repeating; other digits steady.
- Two loads (16'h1111 then 16'h2222) in one frame, with a third load (16'h3333) on the boundary cycle -> frame+1 shows 2222; frame+2 shows 3333; ready low throughout, high after the second boundary.
- Assert reset mid-frame with a pending update -> outputs return to reset values asynchronously; pending value never displayed after release.
